// File: rtl/pc_ctrl_pkg.sv
// Shared types for the fetch-stage PC sequencer.
// Optional return stack is enabled with PC_CALL_STACK_EN.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    HOLD,
    INC,
    ABS,
    REL,
    ZERO,
    POP
  } pc_sel_t;

  localparam int STACK_DEPTH = 4;

endpackage

// File: rtl/pc_ret_stack.sv
// Small LIFO holding return addresses for call/ret.
// Only instantiated when PC_CALL_STACK_EN is defined.
module pc_ret_stack
  import pc_ctrl_pkg::*;
#(
  parameter int W     = 10,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULLV = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] top;

  assign full_o  = (cnt_q == FULLV);
  assign empty_o = (cnt_q == '0);
  assign top     = cnt_q - C_ONE;
  assign data_o  = mem_q[top[AW-1:0]];

  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (pop_i && !empty_o) begin
      cnt_q <= cnt_q - C_ONE;
    end else if (push_i && !full_o) begin
      mem_q[cnt_q[AW-1:0]] <= data_i;
      cnt_q <= cnt_q + C_ONE;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch-stage PC sequencer: run/halt FSM, next-PC select, cycle counter.
// Define PC_CALL_STACK_EN to add call/ret with a 4-entry return stack.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int D      = 10,
  parameter int LUT_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              branch_en,
  input  logic              branch_rel,
  input  logic [LUT_AW-1:0] lut_idx,
  output logic [LUT_AW-1:0] lut_addr,
  input  logic [D-1:0]      lut_target,
  output logic [D-1:0]      pc,
  output logic              running,
  output logic              done,
  output logic [CNT_W-1:0]  cycle_cnt
`ifdef PC_CALL_STACK_EN
  ,
  input  logic              call,
  input  logic              ret,
  output logic              stack_err
`endif
);

  state_t           state_q, state_d;
  pc_sel_t          sel;
  logic [D-1:0]     pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef PC_CALL_STACK_EN
  logic         err_q, err_d;
  logic         push, pop;
  logic         stk_full, stk_empty;
  logic [D-1:0] stk_data;

  pc_ret_stack #(
    .W    (D),
    .DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk    (clk),
    .clr_i  (reset || (sel == ZERO)),
    .push_i (push),
    .pop_i  (pop),
    .data_i (pc_q + D'(1)),
    .data_o (stk_data),
    .full_o (stk_full),
    .empty_o(stk_empty)
  );

  assign stack_err = err_q;
`endif

  always_comb begin
    state_d = state_q;
    sel     = HOLD;
`ifdef PC_CALL_STACK_EN
    err_d   = err_q;
    push    = 1'b0;
    pop     = 1'b0;
`endif
    unique case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = RUN;
          sel     = ZERO;
`ifdef PC_CALL_STACK_EN
          err_d   = 1'b0;
`endif
        end
      end
      RUN: begin
        priority case (1'b1)
          stall:    sel = HOLD;
          halt_req: state_d = HALT;
`ifdef PC_CALL_STACK_EN
          ret: begin
            pop = !stk_empty;
            sel = stk_empty ? INC : POP;
            if (stk_empty) err_d = 1'b1;
          end
          call: begin
            push = !stk_full;
            sel  = ABS;
            if (stk_full) err_d = 1'b1;
          end
`endif
          branch_en: sel = branch_rel ? REL : ABS;
          default:   sel = INC;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    unique case (sel)
      INC:  pc_d = pc_q + D'(1);
      ABS:  pc_d = lut_target;
      REL:  pc_d = pc_q + lut_target;
      ZERO: pc_d = '0;
`ifdef PC_CALL_STACK_EN
      POP:  pc_d = stk_data;
`endif
      default: pc_d = pc_q;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (sel == ZERO) begin
      cnt_d = '0;
    end else if (state_q == RUN && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
`ifdef PC_CALL_STACK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
`ifdef PC_CALL_STACK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign lut_addr  = lut_idx;
  assign pc        = pc_q;
  assign running   = (state_q == RUN);
  assign done      = (state_q == HALT);
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl with a behavioural target LUT.
// Stack sequences run only when PC_CALL_STACK_EN is defined.
module tb_pc_ctrl;

  typedef struct {
    logic        rst, st, stl, hlt, br, rel, cl, rt;
    logic [3:0]  idx;
    logic [9:0]  pc;
    logic        run, dn, err;
    logic [15:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, start, stall, halt_req, branch_en, branch_rel;
  logic        call, ret;
  logic        stack_err;
  logic [3:0]  lut_idx, lut_addr;
  logic [9:0]  lut_target, pc;
  logic        running, done;
  logic [15:0] cycle_cnt;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  always_comb begin
    case (lut_addr)
      4'd1:    lut_target = 10'd11;
      4'd2:    lut_target = 10'd20;
      4'd3:    lut_target = 10'd111;
      4'd4:    lut_target = 10'd50;
      4'd5:    lut_target = 10'd1023;
      4'd7:    lut_target = 10'd108;
      4'd9:    lut_target = 10'h3FB;
      default: lut_target = 10'd0;
    endcase
  end

  pc_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stall     (stall),
    .halt_req  (halt_req),
    .branch_en (branch_en),
    .branch_rel(branch_rel),
    .lut_idx   (lut_idx),
    .lut_addr  (lut_addr),
    .lut_target(lut_target),
    .pc        (pc),
    .running   (running),
    .done      (done),
    .cycle_cnt (cycle_cnt)
`ifdef PC_CALL_STACK_EN
    ,
    .call      (call),
    .ret       (ret),
    .stack_err (stack_err)
`endif
  );

`ifndef PC_CALL_STACK_EN
  assign stack_err = 1'b0;
`endif

  function automatic vec_t mk(
    input logic rst, st, stl, hlt, br, rel,
    input int idx, epc, input logic run, dn,
    input int cnt);
    vec_t v;
    v.rst = rst; v.st = st; v.stl = stl; v.hlt = hlt;
    v.br = br; v.rel = rel; v.cl = 1'b0; v.rt = 1'b0;
    v.idx = 4'(idx); v.pc = 10'(epc);
    v.run = run; v.dn = dn; v.err = 1'b0;
    v.cnt = 16'(cnt);
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t v, input bit chk_err);
    vec_t e;
    reset      = v.rst;
    start      = v.st;
    stall      = v.stl;
    halt_req   = v.hlt;
    branch_en  = v.br;
    branch_rel = v.rel;
    call       = v.cl;
    ret        = v.rt;
    lut_idx    = v.idx;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("pc", int'(pc), int'(e.pc));
    chk("running", int'(running), int'(e.run));
    chk("done", int'(done), int'(e.dn));
    chk("cycle_cnt", int'(cycle_cnt), int'(e.cnt));
    chk("lut_addr", int'(lut_addr), int'(e.idx));
    if (chk_err) chk("stack_err", int'(stack_err), int'(e.err));
  endtask

`ifdef PC_CALL_STACK_EN
  task automatic stk(input logic cl, rt, input int idx,
                     input int epc, input int cnt, input logic err);
    vec_t v;
    v = mk(0, 0, 0, 0, 0, 0, idx, epc, 1, 0, cnt);
    v.cl = cl; v.rt = rt; v.err = err;
    step(v, 1'b1);
  endtask
`endif

  initial begin
    reset = 1'b1; start = 0; stall = 0; halt_req = 0;
    branch_en = 0; branch_rel = 0; call = 0; ret = 0;
    lut_idx = 4'd0;

    tbl.push_back(mk(1,0,0,0,1,0, 9,   0,0,0, 0));
    tbl.push_back(mk(1,0,0,0,0,0, 9,   0,0,0, 0));
    tbl.push_back(mk(0,1,0,0,0,0, 0,   0,1,0, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,   1,1,0, 1));
    tbl.push_back(mk(0,0,0,0,0,0, 0,   2,1,0, 2));
    tbl.push_back(mk(0,0,0,0,0,0, 0,   3,1,0, 3));
    tbl.push_back(mk(0,0,0,0,0,0, 0,   4,1,0, 4));
    tbl.push_back(mk(0,0,0,0,1,0, 3, 111,1,0, 5));
    tbl.push_back(mk(0,0,1,0,1,0, 2, 111,1,0, 6));
    tbl.push_back(mk(0,0,1,0,0,0, 0, 111,1,0, 7));
    tbl.push_back(mk(0,0,0,0,1,0, 2,  20,1,0, 8));
    tbl.push_back(mk(0,0,0,0,1,1, 9,  15,1,0, 9));
    tbl.push_back(mk(0,1,0,0,0,0, 0,  16,1,0,10));
    tbl.push_back(mk(0,0,0,0,1,0, 5,1023,1,0,11));
    tbl.push_back(mk(0,0,0,0,0,0, 0,   0,1,0,12));
    for (int i = 1; i <= 7; i++)
      tbl.push_back(mk(0,0,0,0,0,0, 0, i,1,0, 12 + i));
    tbl.push_back(mk(0,0,0,1,1,0, 7,   7,0,1,20));
    tbl.push_back(mk(0,0,0,0,0,0, 0,   7,0,1,20));
    tbl.push_back(mk(0,0,1,1,1,0, 3,   7,0,1,20));
    tbl.push_back(mk(0,1,0,0,0,0, 0,   0,1,0, 0));
    tbl.push_back(mk(0,0,1,1,0,0, 0,   0,1,0, 1));
    tbl.push_back(mk(0,0,0,0,1,0, 4,  50,1,0, 2));
    tbl.push_back(mk(1,0,0,0,1,0, 3,   0,0,0, 0));
    tbl.push_back(mk(0,0,1,1,1,0, 3,   0,0,0, 0));

    foreach (tbl[i]) step(tbl[i], 1'b0);

    // Long run to reach counter saturation; pc wraps along the way.
    step(mk(0,1,0,0,0,0, 0, 0,1,0, 0), 1'b0);
    start = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    step(mk(0,0,0,0,0,0, 0, 1023,1,0, 65535), 1'b0);
    step(mk(0,0,0,0,0,0, 0,    0,1,0, 65535), 1'b0);

`ifdef PC_CALL_STACK_EN
    step(mk(1,0,0,0,0,0, 0, 0,0,0, 0), 1'b1);
    step(mk(0,1,0,0,0,0, 0, 0,1,0, 0), 1'b1);
    for (int i = 1; i <= 5; i++) stk(0, 0, 0, i, i, 0);
    stk(1, 0, 1, 11, 6, 0);
    stk(0, 0, 0, 12, 7, 0);
    stk(0, 1, 0,  6, 8, 0);
    for (int i = 0; i < 4; i++) stk(1, 0, 1, 11, 9 + i, 0);
    stk(1, 0, 1, 11, 13, 1);
    begin
      vec_t v;
      v = mk(0,0,0,1,0,0, 0, 11,0,1, 14);
      v.err = 1'b1;
      step(v, 1'b1);
      v = mk(0,1,0,0,0,0, 0, 0,1,0, 0);
      step(v, 1'b1);
    end
    stk(0, 1, 0, 1, 1, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

- Program-counter sequencer for the processor's fetch stage.
- Owns the PC register and the run/halt state machine, and drives the 4-bit address of the branch-target lookup table.
- Selects the next PC from increment, absolute LUT target or PC-relative LUT target.
- Sits between the decode/branch-resolve logic and instruction memory; the target LUT stays a separate combinational block.

## Interface
- D, 10: PC width; all PC arithmetic is modulo 2^D.
- LUT_AW, 4: LUT index width.
- CNT_W, 16: cycle-counter width.
- clk  in  1: clock, rising edge.
- reset  in  1: synchronous, active-high.
- start  in  1: begin execution at PC 0.
- stall  in  1: hold PC this cycle.
- halt_req  in  1: decoded halt instruction.
- branch_en  in  1: branch taken this cycle (condition already resolved).
- branch_rel  in  1: 1 = lut_target is a signed offset; 0 = lut_target is an absolute address.
- lut_idx  in  LUT_AW: branch target index from decode.
- lut_addr  out  LUT_AW: address to the target LUT.
- lut_target  in  D: LUT data, combinational from lut_addr.
- pc  out  D: current PC, registered.
- running  out  1: state is RUN.
- done  out  1: state is HALT.
- cycle_cnt  out  CNT_W: cycles spent in RUN, saturating.

## Operation
- **States:** IDLE, RUN, HALT.
  - reset → IDLE.
  - IDLE, start → RUN.
  - RUN, halt_req and !stall → HALT.
  - HALT, start → RUN.
  - Any other input combination holds the current state.
- **Entering RUN** (from IDLE or HALT): pc ← 0 and cycle_cnt ← 0.
- **RUN priority, per cycle:** stall > halt_req > branch_en > increment.
  - stall: pc and state hold.
  - halt_req: pc holds and state goes to HALT. A simultaneous branch_en is ignored.
  - branch_en with branch_rel=0: pc ← lut_target.
  - branch_en with branch_rel=1: pc ← (pc + lut_target) mod 2^D, with lut_target read as two's complement. Example: 0x3FB = −5.
  - otherwise: pc ← pc + 1, wrapping 2^D−1 → 0.
- **IDLE/HALT:** pc holds; branch_en, stall and halt_req are ignored.
- **lut_addr:** always equals lut_idx (combinational pass-through). It is registered nowhere.
- **cycle_cnt:** increments on every RUN cycle, stalls included. It saturates at 2^CNT_W−1 and holds in IDLE/HALT.
- **Reset mid-run:** returns the block to IDLE with pc=0 on the next edge and discards any in-flight branch.

## Timing
- **Reset values:** pc=0, running=0, done=0, cycle_cnt=0. lut_addr tracks lut_idx even during reset.
- **Branch latency:** one cycle. A branch_en sampled at edge N makes pc equal the target after edge N.
- **start latency:** running=1 in the cycle after start is sampled, with pc=0.
- **halt latency:** done=1 in the cycle after halt_req is sampled. pc shows the halt instruction's address.
- **start asserted while RUN:** ignored; the PC is not restarted.

## Configuration
- **Macro:** PC_CALL_STACK_EN.
- **When defined:**
  - Added ports: call in 1, ret in 1, stack_err out 1.
  - Adds a 4-entry return stack.
  - call: push pc+1, then pc ← lut_target (absolute only).
  - ret: pc ← popped value.
  - Priority: stall > halt_req > ret > call > branch_en > increment.
  - call when the stack is full: the branch still happens, the push is dropped, and stack_err is set.
  - ret when the stack is empty: pc ← pc+1 and stack_err is set.
  - stack_err is sticky until reset or start. The stack empties on reset and on entering RUN.
- **When undefined:** the call, ret and stack_err ports and the stack logic do not exist. Behaviour is exactly as above.

## Structure
- **pc_ctrl_pkg** holds:
  - state_t enum (IDLE, RUN, HALT);
  - next-PC select enum (HOLD, INC, ABS, REL, ZERO, POP);
  - STACK_DEPTH=4.
- **Sub-module pc_ret_stack:** the LIFO with push, pop, full, empty and data. It is instantiated only under PC_CALL_STACK_EN.

## Test plan
The bench models the LUT with idx1=11, idx3=111, idx7=108, idx9=0x3FB (−5).

- reset, then start; run 4 cycles with no branch → pc 0,1,2,3,4; running=1; cycle_cnt=4.
- At pc=4, branch_en with branch_rel=0 and lut_idx=3 → pc=111 next cycle. Assert stall for 2 cycles → pc stays 111 and cycle_cnt still advances.
- At pc=20, branch_en with branch_rel=1 and lut_idx=9 → pc=15. Force pc to 1023 and increment → pc=0.
- halt_req together with branch_en at pc=7 → done=1, pc=7. Then start → pc=0, running=1, cycle_cnt=0.
- reset asserted mid-branch at pc=50 → next cycle pc=0, state IDLE, all outputs at reset values.
- With PC_CALL_STACK_EN defined:
  - call with lut_idx=1 at pc=5 → pc=11; a later ret → pc=6.
  - Five nested calls → stack_err=1.
  - ret with the stack empty → pc+1 and stack_err=1.
